// File: rtl/adc_spi_reader.sv
// Serial-ADC front end: periodic conversion trigger, CPOL=0 SPI frame capture, sample strobe.
// Optional macro ADC_HOLD_ON_ERR_EN: keep the previous sample when the null bit is wrong.
module adc_spi_reader #(
  parameter int ADC_WIDTH = 10,
  parameter int SCLK_DIV  = 25,
  parameter int PERIOD    = 15200
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 sclr,
  input  logic                 ena,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  input  logic                 adc_miso,
  output logic [ADC_WIDTH-1:0] adc,
  output logic                 adc_err,
  output logic                 adc_valid,
  output logic                 busy
);

  localparam int FRAME_BITS = ADC_WIDTH + 6;
  localparam int PER_W      = $clog2(PERIOD);
  localparam int DIV_W      = $clog2(SCLK_DIV);
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] NULL_IDX   = BIT_W'(3);
  localparam logic [BIT_W-1:0] DATA_FIRST = BIT_W'(4);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(ADC_WIDTH + 3);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [PER_W-1:0]       per_q, per_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic                   hi_q, hi_d;
  logic [ADC_WIDTH-1:0]   shreg_q, shreg_d;
  logic                   null_q, null_d;
  logic                   cs_n_q, cs_n_d;
  logic                   sclk_q, sclk_d;
  logic [ADC_WIDTH-1:0]   adc_q, adc_d;
  logic                   err_q, err_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;

  logic                   tick;
  logic                   samp;
  logic [BIT_W-1:0]       samp_idx;

  assign tick = ena && (per_q == PER_LAST);

  // Conversion period counter; parked at zero while triggering is disabled.
  always_comb begin
    per_d = per_q;
    if (sclr) begin
      per_d = '0;
    end else if (!ena) begin
      per_d = '0;
    end else if (per_q == PER_LAST) begin
      per_d = '0;
    end else begin
      per_d = per_q + 1'b1;
    end
  end

  // Frame sequencer: next state, SPI pins, sampling requests and sample hand-off.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    hi_d     = hi_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    adc_d    = adc_q;
    err_d    = err_q;
    valid_d  = 1'b0;
    samp     = 1'b0;
    samp_idx = bit_q;
    if (sclr) begin
      state_d = ST_IDLE;
      div_d   = '0;
      bit_d   = '0;
      hi_d    = 1'b0;
      cs_n_d  = 1'b1;
      sclk_d  = 1'b0;
      adc_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cs_n_d = 1'b1;
          sclk_d = 1'b0;
          if (tick) begin
            state_d = ST_SETUP;
            cs_n_d  = 1'b0;
            div_d   = '0;
            bit_d   = '0;
            hi_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (div_q == DIV_LAST) begin
            state_d  = ST_SHIFT;
            div_d    = '0;
            sclk_d   = 1'b1;
            hi_d     = 1'b1;
            samp     = 1'b1;
            samp_idx = '0;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (div_q != DIV_LAST) begin
            div_d = div_q + 1'b1;
          end else begin
            div_d = '0;
            if (hi_q) begin
              sclk_d = 1'b0;
              hi_d   = 1'b0;
            end else if (bit_q == BIT_LAST) begin
              state_d = ST_HOLD;
            end else begin
              // Rising SCLK edge of the next bit: capture MISO on the same clk.
              bit_d    = bit_q + 1'b1;
              sclk_d   = 1'b1;
              hi_d     = 1'b1;
              samp     = 1'b1;
              samp_idx = bit_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (div_q == DIV_LAST) begin
            state_d = ST_IDLE;
            div_d   = '0;
            bit_d   = '0;
            cs_n_d  = 1'b1;
            valid_d = 1'b1;
            err_d   = null_q;
`ifdef ADC_HOLD_ON_ERR_EN
            adc_d   = null_q ? adc_q : shreg_q;
`else
            adc_d   = shreg_q;
`endif
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          div_d   = '0;
          bit_d   = '0;
          hi_d    = 1'b0;
          cs_n_d  = 1'b1;
          sclk_d  = 1'b0;
        end
      endcase
    end
    busy_d = ~cs_n_d;
  end

  // Bit capture: null bit flag and MSB-first data shift register.
  always_comb begin
    shreg_d = shreg_q;
    null_d  = null_q;
    if (sclr) begin
      shreg_d = '0;
      null_d  = 1'b0;
    end else if (samp) begin
      if (samp_idx == NULL_IDX) begin
        null_d = adc_miso;
      end else begin
        null_d = null_q;
      end
      if ((samp_idx >= DATA_FIRST) && (samp_idx <= DATA_LAST)) begin
        shreg_d = {shreg_q[ADC_WIDTH-2:0], adc_miso};
      end else begin
        shreg_d = shreg_q;
      end
    end else begin
      shreg_d = shreg_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, capture registers and registered outputs.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      per_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      hi_q    <= 1'b0;
      shreg_q <= '0;
      null_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      adc_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      per_q   <= per_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      hi_q    <= hi_d;
      shreg_q <= shreg_d;
      null_q  <= null_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      adc_q   <= adc_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign adc_cs_n  = cs_n_q;
  assign adc_sclk  = sclk_q;
  assign adc       = adc_q;
  assign adc_err   = err_q;
  assign adc_valid = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Self-checking bench for adc_spi_reader: SPI converter model, expected-sample scoreboard.
`timescale 1ns/1ps
module tb_adc_spi_reader;

  localparam int AW     = 10;
  localparam int SD     = 5;
  localparam int PER    = 400;
  localparam int FB     = AW + 6;
  localparam int LOW    = (2 * FB + 2) * SD;
  localparam int BUDGET = 2 * PER + LOW;

  logic          clk  = 1'b0;
  logic          aclr = 1'b1;
  logic          sclr = 1'b0;
  logic          ena  = 1'b0;
  logic          adc_miso = 1'b0;
  logic          adc_cs_n, adc_sclk, adc_err, adc_valid, busy;
  logic [AW-1:0] adc;

  adc_spi_reader #(.ADC_WIDTH(AW), .SCLK_DIV(SD), .PERIOD(PER)) dut (
    .clk(clk), .aclr(aclr), .sclr(sclr), .ena(ena),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_miso(adc_miso),
    .adc(adc), .adc_err(adc_err), .adc_valid(adc_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] adc; logic err; } exp_t;
  exp_t          exp_q[$];
  logic [FB-1:0] cur_frame = '0;
  logic [AW-1:0] model_adc = '0;
  int vectors = 0, miscompares = 0;

  int   cyc = 0, low_cnt = 0, rise_cnt = 0, fall_cnt = 0, stray_cnt = 0, busy_bad = 0;
  int   last_low_len = 0, last_rises = 0, last_valid_cyc = 0, prev_valid_cyc = 0;
  logic prev_cs_n = 1'b1, prev_sclk = 1'b0;

  // Converter model and bus monitor: MISO carries bit k before the k-th SCLK rise.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!adc_cs_n) begin
      if (prev_cs_n) begin
        low_cnt = 0; rise_cnt = 0; fall_cnt = fall_cnt + 1;
      end
      low_cnt = low_cnt + 1;
      if (adc_sclk && !prev_sclk) rise_cnt = rise_cnt + 1;
    end else begin
      if (!prev_cs_n) begin
        last_low_len = low_cnt; last_rises = rise_cnt;
      end
      if (adc_sclk) stray_cnt = stray_cnt + 1;
    end
    if (busy !== ~adc_cs_n) busy_bad = busy_bad + 1;
    if (adc_valid) begin
      prev_valid_cyc = last_valid_cyc; last_valid_cyc = cyc;
    end
    adc_miso  = (!adc_cs_n && rise_cnt < FB) ? cur_frame[rise_cnt] : 1'b0;
    prev_cs_n = adc_cs_n;
    prev_sclk = adc_sclk;
  end

  function automatic logic [FB-1:0] make_frame(input logic [AW-1:0] d, input logic nul, input logic junk);
    logic [FB-1:0] f;
    f = '0;
    for (int i = 0; i < 3; i++) f[i] = junk;
    f[3] = nul;
    for (int i = 0; i < AW; i++) f[4+i] = d[AW-1-i];
    f[FB-2] = junk;
    f[FB-1] = junk;
    return f;
  endfunction

  task automatic load_frame(input logic [AW-1:0] d, input logic nul, input logic junk);
    exp_t e;
    cur_frame = make_frame(d, nul, junk);
`ifdef ADC_HOLD_ON_ERR_EN
    if (!nul) model_adc = d;
`else
    model_adc = d;
`endif
    e.adc = model_adc;
    e.err = nul;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk); #1;
      if (adc_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    aclr = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({adc_cs_n, adc_sclk, adc, adc_err, adc_valid, busy} !== {1'b1, 1'b0, {AW{1'b0}}, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got cs_n=%b sclk=%b adc=%h err=%b valid=%b busy=%b, want 1 0 000 0 0 0",
               adc_cs_n, adc_sclk, adc, adc_err, adc_valid, busy);
    end
    aclr = 1'b0;
    repeat (PER + 10) @(negedge clk);
    #1;
    vectors++;
    if (fall_cnt !== 0) begin
      miscompares++;
      $display("FAIL idle_no_frame: got %0d cs_n falls with ena=0, want 0", fall_cnt);
    end
  endtask

  task automatic test_basic;
    exp_t e; bit ok; int f0;
    load_frame(10'h2A5, 1'b0, 1'b1);
    f0  = fall_cnt;
    ena = 1'b1;
    wait_valid(ok);
    e = exp_q.pop_front();
    vectors += 6;
    if (!ok) begin miscompares++; $display("FAIL basic_timeout: no strobe in %0d clks", BUDGET); end
    if (adc !== e.adc) begin miscompares++; $display("FAIL basic_adc: got %h want %h", adc, e.adc); end
    if (adc_err !== e.err) begin miscompares++; $display("FAIL basic_err: got %b want %b", adc_err, e.err); end
    if (last_low_len !== LOW) begin miscompares++; $display("FAIL basic_cs_low: got %0d clks want %0d", last_low_len, LOW); end
    if (last_rises !== FB) begin miscompares++; $display("FAIL basic_sclk_rises: got %0d want %0d", last_rises, FB); end
    if (fall_cnt - f0 !== 1) begin miscompares++; $display("FAIL basic_frames: got %0d want 1", fall_cnt - f0); end
    @(negedge clk); #1;
    vectors += 2;
    if (adc_valid !== 1'b0) begin miscompares++; $display("FAIL basic_strobe_width: got valid=%b want 0", adc_valid); end
    if (adc !== e.adc) begin miscompares++; $display("FAIL basic_adc_hold: got %h want %h", adc, e.adc); end
  endtask

  task automatic test_back_to_back;
    exp_t e; bit ok;
    logic [AW-1:0] d3 [3];
    d3[0] = 10'h1C3; d3[1] = 10'h03C; d3[2] = 10'h2F0;
    for (int i = 0; i < 3; i++) begin
      load_frame(d3[i], 1'b0, i[0]);
      wait_valid(ok);
      e = exp_q.pop_front();
      vectors += 3;
      if (!ok || adc !== e.adc) begin miscompares++; $display("FAIL b2b_adc[%0d]: got %h want %h", i, adc, e.adc); end
      if (adc_err !== e.err) begin miscompares++; $display("FAIL b2b_err[%0d]: got %b want %b", i, adc_err, e.err); end
      if (last_valid_cyc - prev_valid_cyc !== PER) begin
        miscompares++;
        $display("FAIL b2b_spacing[%0d]: got %0d clks want %0d", i, last_valid_cyc - prev_valid_cyc, PER);
      end
    end
    vectors += 2;
    if (stray_cnt !== 0) begin miscompares++; $display("FAIL b2b_stray_sclk: got %0d clks of SCLK high with cs_n=1, want 0", stray_cnt); end
    if (busy_bad !== 0) begin miscompares++; $display("FAIL b2b_busy: got %0d clks busy!=!cs_n, want 0", busy_bad); end
  endtask

  task automatic test_error;
    exp_t e; bit ok;
    logic [AW-1:0] d3 [3];
    logic          n3 [3];
    d3[0] = 10'h2A5; d3[1] = 10'h155; d3[2] = 10'h0F0;
    n3[0] = 1'b0;    n3[1] = 1'b1;    n3[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_frame(d3[i], n3[i], 1'b0);
      wait_valid(ok);
      e = exp_q.pop_front();
      vectors += 2;
      if (!ok || adc !== e.adc) begin miscompares++; $display("FAIL err_adc[%0d]: got %h want %h", i, adc, e.adc); end
      if (adc_err !== e.err) begin miscompares++; $display("FAIL err_flag[%0d]: got %b want %b", i, adc_err, e.err); end
    end
  endtask

  task automatic test_sclr_abort;
    exp_t e; bit ok; int s_cyc;
    load_frame(10'h3A1, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk); #1;
      if (!adc_cs_n && rise_cnt == 8) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL sclr_reach_bit7: bit 7 not reached in %0d clks", BUDGET); end
    sclr = 1'b1;
    @(negedge clk); #1;
    sclr  = 1'b0;
    s_cyc = cyc;
    vectors++;
    if ({adc_cs_n, adc_sclk, adc, adc_err, adc_valid, busy} !== {1'b1, 1'b0, {AW{1'b0}}, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL sclr_outputs: got cs_n=%b sclk=%b adc=%h err=%b valid=%b busy=%b, want 1 0 000 0 0 0",
               adc_cs_n, adc_sclk, adc, adc_err, adc_valid, busy);
    end
    void'(exp_q.pop_back());
    model_adc = '0;
    load_frame(10'h2B6, 1'b0, 1'b1);
    wait_valid(ok);
    e = exp_q.pop_front();
    vectors += 4;
    if (!ok || adc !== e.adc) begin miscompares++; $display("FAIL sclr_next_adc: got %h want %h", adc, e.adc); end
    if (adc_err !== e.err) begin miscompares++; $display("FAIL sclr_next_err: got %b want %b", adc_err, e.err); end
    if (last_low_len !== LOW) begin miscompares++; $display("FAIL sclr_next_cs_low: got %0d want %0d", last_low_len, LOW); end
    if (cyc - s_cyc < PER) begin miscompares++; $display("FAIL sclr_no_strobe: strobe %0d clks after clear, want >= %0d", cyc - s_cyc, PER); end
  endtask

  task automatic test_ena_drop;
    exp_t e; bit ok; int f0;
    load_frame(10'h0C5, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk); #1;
      if (!adc_cs_n) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL drop_frame_start: no cs_n fall in %0d clks", BUDGET); end
    repeat (40) @(negedge clk);
    ena = 1'b0;
    wait_valid(ok);
    e  = exp_q.pop_front();
    f0 = fall_cnt;
    vectors += 2;
    if (!ok || adc !== e.adc) begin miscompares++; $display("FAIL drop_adc: got %h want %h", adc, e.adc); end
    if (adc_err !== e.err) begin miscompares++; $display("FAIL drop_err: got %b want %b", adc_err, e.err); end
    repeat (2 * PER) @(negedge clk);
    #1;
    vectors++;
    if (fall_cnt !== f0) begin miscompares++; $display("FAIL drop_no_restart: got %0d new frames want 0", fall_cnt - f0); end
  endtask

  task automatic test_extremes;
    exp_t e; bit ok;
    logic [AW-1:0] d2 [2];
    d2[0] = 10'h000; d2[1] = 10'h3FF;
    ena = 1'b1;
    for (int i = 0; i < 2; i++) begin
      load_frame(d2[i], 1'b0, ~i[0]);
      wait_valid(ok);
      e = exp_q.pop_front();
      vectors += 2;
      if (!ok || adc !== e.adc) begin miscompares++; $display("FAIL extreme_adc[%0d]: got %h want %h", i, adc, e.adc); end
      if (adc_err !== e.err) begin miscompares++; $display("FAIL extreme_err[%0d]: got %b want %b", i, adc_err, e.err); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_error();
    test_sclr_abort();
    test_ena_drop();
    test_extremes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
